// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
// Memory-side responder for the LC-3 pipeline controller. It has two independent
// request/complete channels: instruction fetch and data access. Each channel has its
// own IDLE/BUSY/DONE state machine and a fixed-latency counter. Both channels share
// one word array, which has two registered read paths and one write path.
// Only the low AW address bits select a word, so higher addresses wrap.
module lc3_mem_responder #(
    parameter int    AW        = 10,
    parameter int    I_LAT     = 1,
    parameter int    D_LAT     = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset,
    // instruction channel
    input  logic        enable_fetch,
    input  logic [15:0] pc,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    // data channel
    input  logic [1:0]  mem_state,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data
);

    localparam int DEPTH = 1 << AW;
    // The counter only ever holds LAT-1 down to 1, so clog2(LAT) bits are enough.
    localparam int I_CW  = (I_LAT > 1) ? $clog2(I_LAT) : 1;
    localparam int D_CW  = (D_LAT > 1) ? $clog2(D_LAT) : 1;

    // mem_state encoding from the controller. Both read codes do the same thing
    // here, because the controller issues the second access of an indirect read.
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_IND   = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Shared word array
    // ------------------------------------------------------------------
    logic [15:0] mem [0:DEPTH-1];

    // The address bits above AW are deliberately ignored.
    generate
        if (AW < 16) begin : g_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^{pc[15:AW], Data_addr[15:AW]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Instruction channel
    // ------------------------------------------------------------------
    state_t          i_state_q, i_state_d;
    logic [I_CW-1:0] i_cnt_q,   i_cnt_d;
    logic [AW-1:0]   i_addr_q,  i_addr_d;
    logic [AW-1:0]   i_acc_addr;   // address read on the edge that enters DONE
    logic            i_fire;       // this edge enters DONE
    logic            complete_instr_q;
    logic [15:0]     instr_dout_q;

    // Instruction next state: accept in IDLE, count down in BUSY, and stay one cycle in DONE.
    always_comb begin
        i_state_d  = i_state_q;
        i_cnt_d    = i_cnt_q;
        i_addr_d   = i_addr_q;
        i_acc_addr = i_addr_q;
        i_fire     = 1'b0;
        case (i_state_q)
            ST_IDLE: begin
                if (enable_fetch) begin
                    i_addr_d   = pc[AW-1:0];
                    i_acc_addr = pc[AW-1:0];
                    if (I_LAT == 1) begin
                        i_state_d = ST_DONE;
                        i_fire    = 1'b1;
                    end else begin
                        i_cnt_d   = I_CW'(I_LAT - 1);
                        i_state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (i_cnt_q == I_CW'(1)) begin
                    i_cnt_d   = '0;
                    i_state_d = ST_DONE;
                    i_fire    = 1'b1;
                end else begin
                    i_cnt_d = i_cnt_q - I_CW'(1);
                end
            end
            ST_DONE: begin
                // A request that is still held here is not accepted. It is
                // sampled again in IDLE on the next edge.
                i_state_d = ST_IDLE;
            end
            default: i_state_d = ST_IDLE;
        endcase
    end

    // Instruction registers. The fetched word and the complete pulse are loaded on the DONE entry edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_state_q        <= ST_IDLE;
            i_cnt_q          <= '0;
            i_addr_q         <= '0;
            complete_instr_q <= 1'b0;
            instr_dout_q     <= 16'h0000;
        end else begin
            i_state_q        <= i_state_d;
            i_cnt_q          <= i_cnt_d;
            i_addr_q         <= i_addr_d;
            complete_instr_q <= i_fire;
            if (i_fire) begin
                instr_dout_q <= mem[i_acc_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Data channel
    // ------------------------------------------------------------------
    state_t          d_state_q, d_state_d;
    logic [D_CW-1:0] d_cnt_q,   d_cnt_d;
    logic [AW-1:0]   d_addr_q,  d_addr_d;
    logic            d_wr_q,    d_wr_d;     // latched op: 1 = write, 0 = read/indirect
    logic [15:0]     d_wdata_q, d_wdata_d;
    logic [AW-1:0]   d_acc_addr;
    logic            d_acc_wr;
    logic [15:0]     d_acc_wdata;
    logic            d_fire;
    logic            mem_we;
    logic            complete_data_q;
    logic [15:0]     data_dout_q;

    // Data next state. Op, address and write data are latched on acceptance, and later input changes are ignored.
    always_comb begin
        d_state_d   = d_state_q;
        d_cnt_d     = d_cnt_q;
        d_addr_d    = d_addr_q;
        d_wr_d      = d_wr_q;
        d_wdata_d   = d_wdata_q;
        d_acc_addr  = d_addr_q;
        d_acc_wr    = d_wr_q;
        d_acc_wdata = d_wdata_q;
        d_fire      = 1'b0;
        case (d_state_q)
            ST_IDLE: begin
                if (mem_state != OP_IDLE) begin
                    d_addr_d    = Data_addr[AW-1:0];
                    d_wr_d      = (mem_state == OP_WRITE);
                    d_wdata_d   = Data_din;
                    d_acc_addr  = Data_addr[AW-1:0];
                    d_acc_wr    = (mem_state == OP_WRITE);
                    d_acc_wdata = Data_din;
                    if (D_LAT == 1) begin
                        d_state_d = ST_DONE;
                        d_fire    = 1'b1;
                    end else begin
                        d_cnt_d   = D_CW'(D_LAT - 1);
                        d_state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (d_cnt_q == D_CW'(1)) begin
                    d_cnt_d   = '0;
                    d_state_d = ST_DONE;
                    d_fire    = 1'b1;
                end else begin
                    d_cnt_d = d_cnt_q - D_CW'(1);
                end
            end
            ST_DONE: begin
                d_state_d = ST_IDLE;
            end
            default: d_state_d = ST_IDLE;
        endcase
    end

    // A write commits only on the DONE entry edge, and never while reset is held.
    // An abandoned access therefore cannot change the array.
    assign mem_we = d_fire && d_acc_wr && reset;

    // Data registers. Reads load Data_dout on the DONE entry edge, and writes leave it unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_state_q       <= ST_IDLE;
            d_cnt_q         <= '0;
            d_addr_q        <= '0;
            d_wr_q          <= 1'b0;
            d_wdata_q       <= 16'h0000;
            complete_data_q <= 1'b0;
            data_dout_q     <= 16'h0000;
        end else begin
            d_state_q       <= d_state_d;
            d_cnt_q         <= d_cnt_d;
            d_addr_q        <= d_addr_d;
            d_wr_q          <= d_wr_d;
            d_wdata_q       <= d_wdata_d;
            complete_data_q <= d_fire;
            if (d_fire && !d_acc_wr) begin
                data_dout_q <= mem[d_acc_addr];
            end
        end
    end

    // Array write port. A fetch on the same edge still reads the old word.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[d_acc_addr] <= d_acc_wdata;
        end
    end

    assign Instr_dout     = instr_dout_q;
    assign complete_instr = complete_instr_q;
    assign Data_dout      = data_dout_q;
    assign complete_data  = complete_data_q;

endmodule
